conv_window_scheduler: RTL
==========================

# conv_window_scheduler

Sequencing and flow-control block for the convolver datapath. Accepts column-load events from the AHB slave and sequences the sample shift register and the multiplier/adder tree. Issues a convolution only once a full 3-column window is present and the result FIFO has a guaranteed free slot. Gates result writes into the FIFO and reports overrun and spurious-result errors back to the slave.

## Interface

Parameters:
- FIFO_DEPTH, 8: result FIFO capacity; initial and maximum credit count.
- WINDOW_COLS, 3: columns needed before a window is valid.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- n_rst  in  1  asynchronous active-low reset
- sample_load_en  in  1  one-cycle pulse: new sample column ready from slave
- new_row  in  1  qualifies sample_load_en: column is first of a new row
- fifo_read  in  1  one-cycle pulse: slave popped one result from FIFO
- result_ready  in  1  one-cycle pulse: multiplier/adder tree produced a result
- modwait  out  1  scheduler busy; slave must not issue sample_load_en
- sample_shift  out  1  one-cycle shift strobe to sample shift register
- convolve_en  out  1  one-cycle start strobe to multiplier/adder tree
- fifo_wenable  out  1  write strobe to result FIFO
- overrun  out  1  one-cycle pulse: sample_load_en received while busy (dropped)
- spurious  out  1  one-cycle pulse: result_ready with no convolution in flight

## Operation

- Reset values:
  - state IDLE
  - col_count 0
  - credit FIFO_DEPTH
  - pending 0
  - all outputs 0
- State machine: IDLE, SHIFT, CONV, STALL. Moore outputs decoded from registered state.
- IDLE:
  - On sample_load_en, go to SHIFT.
  - If new_row is also high, col_count is cleared to 0 on the same edge.
- SHIFT:
  - sample_shift=1.
  - col_count increments, saturating at WINDOW_COLS.
  - If the incremented col_count equals WINDOW_COLS: go to CONV when credit>0, else STALL.
  - Otherwise go to IDLE.
- STALL: outputs 0; hold until credit>0, then go to CONV.
- CONV:
  - convolve_en=1.
  - credit decrements, pending increments.
  - Return to IDLE.
- modwait=1 in every state except IDLE.
- Credit counter, width $clog2(FIFO_DEPTH+1):
  - +1 on fifo_read.
  - −1 in CONV.
  - Both in the same cycle: unchanged.
  - fifo_read at credit==FIFO_DEPTH (no CONV that cycle) is ignored; credit saturates.
- Pending counter, same width as credit:
  - +1 in CONV.
  - −1 on valid result_ready.
  - Both in the same cycle: unchanged.
- fifo_wenable = result_ready && pending!=0 (combinational).
- result_ready with pending==0: no FIFO write, pending unchanged, spurious pulses the next cycle.
- sample_load_en when state!=IDLE: ignored (no shift, col_count unchanged, new_row ignored); overrun pulses the next cycle.
- Once a row holds WINDOW_COLS columns, every further column without new_row produces one convolution (sliding window).
- Asynchronous reset mid-operation (including STALL): immediate return to reset values. In-flight results are forgotten, and subsequent result_ready is flagged spurious.

## Timing

- sample_load_en sampled at edge t in IDLE:
  - sample_shift high during cycle t+1.
  - convolve_en high during cycle t+2 if the window is full and credit>0.
  - modwait high from t+1 until the state returns to IDLE.
- Next accepted load:
  - Earliest at t+2 when no convolution is issued.
  - Earliest at t+3 when a convolution is issued.
- STALL exit: fifo_read in cycle s raises credit at edge s+1. CONV (convolve_en) follows in cycle s+2.
- overrun and spurious are registered: high exactly one cycle, the cycle after the offending input.
- Credit guarantees at most FIFO_DEPTH results written but not yet read. fifo_wenable is never asserted into a full FIFO.

## Test plan

- Reset:
  - Assert n_rst=0 mid-cycle → all outputs 0 immediately.
  - After release, 8 convolutions issue without any fifo_read, and the 9th stalls (confirms credit=8).
- Window fill:
  - new_row+load, then two more loads spaced 4 cycles → exactly 3 sample_shift pulses.
  - convolve_en occurs once, 2 cycles after the third load.
  - A fourth load without new_row → a second convolve_en.
- Backpressure:
  - Issue 8 convolutions with no fifo_read; a 9th full window → state holds STALL and modwait stays 1.
  - fifo_read in cycle s → convolve_en in s+2 and modwait drops in s+3.
- Row restart: after 3 loads, a load with new_row → sample_shift but no convolve_en; two further loads are needed before the next convolve_en.
- Overrun: sample_load_en one cycle after an accepted load → overrun pulses one cycle later; sample_shift count unchanged.
- Result gating:
  - 2 convolutions then 3 result_ready pulses → 2 fifo_wenable pulses and 1 spurious pulse.
  - Simultaneous fifo_read and CONV → credit unchanged.

Source files
------------

// File: rtl/conv_window_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_window_scheduler : column/window sequencer with result-FIFO credit flow
// rev 1.0
// ----------------------------------------------------------------------------
module conv_window_scheduler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int WINDOW_COLS = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic sample_load_en,
    input  logic new_row,
    input  logic fifo_read,
    input  logic result_ready,
    output logic modwait,
    output logic sample_shift,
    output logic convolve_en,
    output logic fifo_wenable,
    output logic overrun,
    output logic spurious
);

    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int COLW = $clog2(WINDOW_COLS + 1);
    localparam logic [CW-1:0]   CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic [COLW-1:0] COL_FULL   = COLW'(WINDOW_COLS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CONV  = 2'd2,
        STALL = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [COLW-1:0] col_count;
    logic [COLW-1:0] col_inc;
    logic [CW-1:0]   credit;
    logic [CW-1:0]   pending;
    logic            result_valid;

    // Saturating so a full row keeps producing one window per new column.
    assign col_inc      = (col_count == COL_FULL) ? col_count : col_count + COLW'(1);
    assign result_valid = result_ready && (pending != '0);
    assign fifo_wenable = result_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        modwait      = 1'b1;
        sample_shift = 1'b0;
        convolve_en  = 1'b0;
        case (state)
            IDLE: begin
                modwait = 1'b0;
                if (sample_load_en) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sample_shift = 1'b1;
                if (col_inc == COL_FULL) begin
                    state_next = (credit != '0) ? CONV : STALL;
                end else begin
                    state_next = IDLE;
                end
            end
            CONV: begin
                convolve_en = 1'b1;
                state_next  = IDLE;
            end
            STALL: begin
                if (credit != '0) begin
                    state_next = CONV;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_count <= '0;
        end else if (state == IDLE && sample_load_en && new_row) begin
            col_count <= '0;
        end else if (state == SHIFT) begin
            col_count <= col_inc;
        end
    end

    // Credit tracks free FIFO slots; a read into an already-empty FIFO is ignored.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            credit <= CREDIT_MAX;
        end else begin
            case ({convolve_en, fifo_read})
                2'b10:   credit <= credit - CW'(1);
                2'b01:   if (credit != CREDIT_MAX) credit <= credit + CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending <= '0;
        end else begin
            case ({convolve_en, result_valid})
                2'b10:   pending <= pending + CW'(1);
                2'b01:   pending <= pending - CW'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun  <= 1'b0;
            spurious <= 1'b0;
        end else begin
            overrun  <= sample_load_en && (state != IDLE);
            spurious <= result_ready && (pending == '0);
        end
    end

endmodule
`default_nettype wire
